pi1_arbq: RTL
=============

Name: pi1_arbq

Overview:
- Parametrised N-master to 1-slave PerInt (pi1) arbiter with a registered slave side. It is the next-generation interconnect front-end for multi-PU clusters.
- Generalises the fixed single-queue master fan-in in four ways: selectable round-robin or fixed-priority arbitration, a per-master burst cap, a per-master outstanding-request watchdog, and per-master grant statistics.
- Sits between PUCOUNT pu instances and the shared memory/device pi1 port.

Parameters:
- MASTERCOUNT, 2, number of pi1 masters (1..16).
- ARCHBITSZ, 32, data width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- ARBMODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- MAXBURST, 4, maximum consecutive grants to one master while others wait (1..255).
- TIMEOUT, 1024, slave cycles before an outstanding op is aborted (0 = disabled).

Ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- m_op_i  in  MASTERCOUNT*2  per-master op: 00 NOOP, 01 WR, 10 RD, 11 RW (atomic swap).
- m_addr_i  in  MASTERCOUNT*ADDRBITSZ  per-master word address.
- m_data_i  in  MASTERCOUNT*ARCHBITSZ  per-master write data.
- m_sel_i  in  MASTERCOUNT*(ARCHBITSZ/8)  per-master byte select.
- m_data_o  out  ARCHBITSZ  read data, shared; valid with m_rdy_o.
- m_rdy_o  out  MASTERCOUNT  one-cycle completion pulse per master.
- m_err_o  out  MASTERCOUNT  one-cycle timeout-abort pulse per master.
- s_op_o  out  2  slave op.
- s_addr_o  out  ADDRBITSZ  slave address.
- s_data_o  out  ARCHBITSZ  slave write data.
- s_sel_o  out  ARCHBITSZ/8  slave byte select.
- s_data_i  in  ARCHBITSZ  slave read data.
- s_rdy_i  in  1  slave completion.
- gntcnt_o  out  MASTERCOUNT*16  saturating per-master grant counters.

Behaviour:
- Reset (rst_i==0 at an edge): state IDLE, all outputs 0, s_op_o=NOOP, RR pointer=0, burst count=0, watchdog=0, gntcnt_o=0. A reset mid-operation abandons the op with no m_rdy_o/m_err_o pulse.
- Request: master i requests when m_op_i[i]!=NOOP. A master holds op/addr/data/sel stable until its m_rdy_o or m_err_o pulse.
- FSM:
  - IDLE: when any request exists, select winner W, register W's fields onto s_* and go to ISSUE. Slave-side latency is 1 cycle after the request is first seen.
  - ISSUE: s_op_o held. On s_rdy_i=1: latch s_data_i into m_data_o, pulse m_rdy_o[W] next cycle, s_op_o=NOOP, go to DONE.
  - DONE: one cycle, then IDLE. Back-to-back grants therefore take a minimum of 3 cycles per op.
- Watchdog (TIMEOUT!=0): counts ISSUE cycles. On reaching TIMEOUT, pulse m_err_o[W], drive s_op_o=NOOP, go to DONE. A simultaneous s_rdy_i takes precedence (normal completion).
- Round-robin: search starts at (last W + 1) mod MASTERCOUNT and wraps.
- Fixed priority: lowest requesting index wins.
- Burst cap (both modes): if W equals the previous winner and the burst count has reached MAXBURST while another master requests, that master is skipped for this selection and the burst count resets to 1. With no other requester, the cap is ignored.
- RW op: treated as one indivisible slave op; no special lock.
- gntcnt_o[i]: increments on each IDLE->ISSUE with W==i and saturates at 0xFFFF.
- MASTERCOUNT==1: always grants master 0; the burst cap has no effect.

Decomposition:
- Shared package: op encodings (PINOOP/PIWROP/PIRDOP/PIRWOP), FSM state constants, clog2.
- One sub-module, pi1_arbq_sel: combinational winner select (mode, RR pointer, burst mask) producing a one-hot grant and encoded index.

Test Plan:
- Single master, MASTERCOUNT=2: m0 RD addr 0x10, slave returns 0xDEADBEEF with s_rdy_i 2 cycles after s_op_o -> s_op_o=10 one cycle after the request; m_rdy_o=01 for one cycle; m_data_o=0xDEADBEEF.
- Round-robin, 3 masters continuously requesting -> grant order 0,1,2,0,1,2; gntcnt_o each 2 after 6 ops.
- ARBMODE=1, MAXBURST=2, m0 and m1 always requesting -> grant order 0,0,1,0,0,1.
- TIMEOUT=8, slave never asserts rdy -> m_err_o[W] pulses after 8 ISSUE cycles; s_op_o returns to 00; the next master is granted.
- s_rdy_i asserted in the same cycle the watchdog expires -> m_rdy_o pulse, no m_err_o.
- rst_i low during ISSUE -> next cycle all outputs 0; no rdy/err pulse; RR pointer restarts at 0.

Source files
------------

// File: rtl/pi1_arbq_pkg.sv
// Shared definitions for the pi1 N-to-1 arbiter: op encodings, FSM states and a clog2 helper.
package pi1_arbq_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } arbq_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pi1_arbq_sel.sv
// Combinational winner select: round-robin from ptr_i or fixed priority, with a burst mask.
module pi1_arbq_sel
    import pi1_arbq_pkg::*;
#(
    parameter int unsigned MASTERCOUNT = 2,
    parameter int unsigned ARBMODE     = 0,
    parameter int unsigned IDXW        = 1
) (
    input  logic [MASTERCOUNT-1:0] req_i,
    input  logic [MASTERCOUNT-1:0] mask_i,
    input  logic [IDXW-1:0]        ptr_i,
    output logic                   valid_o,
    output logic [MASTERCOUNT-1:0] gnt_o,
    output logic [IDXW-1:0]        idx_o
);

    logic [MASTERCOUNT-1:0] eff_req;
    logic [IDXW-1:0]        cand;

    always_comb begin
        // The mask only ever removes a master when someone else is still eligible.
        eff_req = ((req_i & ~mask_i) != '0) ? (req_i & ~mask_i) : req_i;
        valid_o = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < MASTERCOUNT; k++) begin
            cand = (ARBMODE == 1) ? IDXW'(k) : IDXW'((32'(ptr_i) + k) % MASTERCOUNT);
            if (!valid_o && eff_req[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/pi1_arbq.sv
// N-master to 1-slave pi1 arbiter with registered slave side, burst cap, watchdog and grant stats.
module pi1_arbq
    import pi1_arbq_pkg::*;
#(
    parameter int unsigned MASTERCOUNT = 2,
    parameter int unsigned ARCHBITSZ   = 32,
    parameter int unsigned ARBMODE     = 0,
    parameter int unsigned MAXBURST    = 4,
    parameter int unsigned TIMEOUT     = 1024,
    localparam int unsigned ADDRBITSZ  = ARCHBITSZ - clog2(ARCHBITSZ / 8),
    localparam int unsigned SELW       = ARCHBITSZ / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [MASTERCOUNT*2-1:0]         m_op_i,
    input  logic [MASTERCOUNT*ADDRBITSZ-1:0] m_addr_i,
    input  logic [MASTERCOUNT*ARCHBITSZ-1:0] m_data_i,
    input  logic [MASTERCOUNT*SELW-1:0]      m_sel_i,
    output logic [ARCHBITSZ-1:0]             m_data_o,
    output logic [MASTERCOUNT-1:0]           m_rdy_o,
    output logic [MASTERCOUNT-1:0]           m_err_o,
    output logic [1:0]                       s_op_o,
    output logic [ADDRBITSZ-1:0]             s_addr_o,
    output logic [ARCHBITSZ-1:0]             s_data_o,
    output logic [SELW-1:0]                  s_sel_o,
    input  logic [ARCHBITSZ-1:0]             s_data_i,
    input  logic                             s_rdy_i,
    output logic [MASTERCOUNT*16-1:0]        gntcnt_o
);

    localparam int unsigned IDXW   = (MASTERCOUNT < 2) ? 1 : clog2(MASTERCOUNT);
    localparam int unsigned WDW    = (TIMEOUT < 2) ? 1 : clog2(TIMEOUT);
    localparam int unsigned WDLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [1:0]           op_arr   [MASTERCOUNT];
    logic [ADDRBITSZ-1:0] addr_arr [MASTERCOUNT];
    logic [ARCHBITSZ-1:0] data_arr [MASTERCOUNT];
    logic [SELW-1:0]      sel_arr  [MASTERCOUNT];
    logic [MASTERCOUNT-1:0] req;

    for (genvar g = 0; g < MASTERCOUNT; g++) begin : g_unpack
        assign op_arr[g]   = m_op_i[2*g +: 2];
        assign addr_arr[g] = m_addr_i[ADDRBITSZ*g +: ADDRBITSZ];
        assign data_arr[g] = m_data_i[ARCHBITSZ*g +: ARCHBITSZ];
        assign sel_arr[g]  = m_sel_i[SELW*g +: SELW];
        assign req[g]      = (m_op_i[2*g +: 2] != PINOOP);
    end

    arbq_state_e          state_q, state_d;
    logic [IDXW-1:0]      win_q, win_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic [IDXW-1:0]      last_q, last_d;
    logic [7:0]           bcnt_q, bcnt_d;
    logic [WDW-1:0]       wdog_q, wdog_d;
    logic [1:0]           s_op_q, s_op_d;
    logic [ADDRBITSZ-1:0] s_addr_q, s_addr_d;
    logic [ARCHBITSZ-1:0] s_data_q, s_data_d;
    logic [SELW-1:0]      s_sel_q, s_sel_d;
    logic [ARCHBITSZ-1:0] mdata_q, mdata_d;
    logic [MASTERCOUNT-1:0] rdy_q, rdy_d;
    logic [MASTERCOUNT-1:0] err_q, err_d;
    logic [15:0]          gntcnt_q [MASTERCOUNT];
    logic [15:0]          gntcnt_d [MASTERCOUNT];

    logic [MASTERCOUNT-1:0] last_oh;
    logic [MASTERCOUNT-1:0] burst_mask;
    logic                   sel_valid;
    logic [MASTERCOUNT-1:0] sel_gnt;
    logic [IDXW-1:0]        sel_idx;
    logic                   wdog_expired;

    // Cap the previous winner only while it is still asking and somebody else is waiting.
    always_comb begin
        last_oh    = MASTERCOUNT'(1) << last_q;
        burst_mask = '0;
        if ((bcnt_q >= 8'(MAXBURST)) && req[last_q] && ((req & ~last_oh) != '0)) begin
            burst_mask = last_oh;
        end
    end

    pi1_arbq_sel #(
        .MASTERCOUNT(MASTERCOUNT),
        .ARBMODE    (ARBMODE),
        .IDXW       (IDXW)
    ) u_sel (
        .req_i  (req),
        .mask_i (burst_mask),
        .ptr_i  (ptr_q),
        .valid_o(sel_valid),
        .gnt_o  (sel_gnt),
        .idx_o  (sel_idx)
    );

    assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDW'(WDLAST));

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        bcnt_d   = bcnt_q;
        wdog_d   = wdog_q;
        s_op_d   = s_op_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        mdata_d  = mdata_q;
        rdy_d    = '0;
        err_d    = '0;
        gntcnt_d = gntcnt_q;
        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    state_d  = StIssue;
                    win_d    = sel_idx;
                    s_op_d   = op_arr[sel_idx];
                    s_addr_d = addr_arr[sel_idx];
                    s_data_d = data_arr[sel_idx];
                    s_sel_d  = sel_arr[sel_idx];
                    wdog_d   = '0;
                    ptr_d    = (sel_idx == IDXW'(MASTERCOUNT - 1)) ? '0 : sel_idx + IDXW'(1);
                    last_d   = sel_idx;
                    if (sel_idx == last_q) begin
                        bcnt_d = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
                    end else begin
                        bcnt_d = 8'd1;
                    end
                    for (int i = 0; i < MASTERCOUNT; i++) begin
                        if (sel_gnt[i] && (gntcnt_q[i] != 16'hFFFF)) begin
                            gntcnt_d[i] = gntcnt_q[i] + 16'd1;
                        end
                    end
                end
            end
            StIssue: begin
                // A completion in the expiry cycle wins over the abort.
                if (s_rdy_i) begin
                    mdata_d      = s_data_i;
                    rdy_d[win_q] = 1'b1;
                    s_op_d       = PINOOP;
                    state_d      = StDone;
                end else if (wdog_expired) begin
                    err_d[win_q] = 1'b1;
                    s_op_d       = PINOOP;
                    state_d      = StDone;
                end else if (TIMEOUT != 0) begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            win_q    <= '0;
            ptr_q    <= '0;
            last_q   <= '0;
            bcnt_q   <= '0;
            wdog_q   <= '0;
            s_op_q   <= PINOOP;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_sel_q  <= '0;
            mdata_q  <= '0;
            rdy_q    <= '0;
            err_q    <= '0;
            for (int i = 0; i < MASTERCOUNT; i++) begin
                gntcnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            bcnt_q   <= bcnt_d;
            wdog_q   <= wdog_d;
            s_op_q   <= s_op_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_sel_q  <= s_sel_d;
            mdata_q  <= mdata_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            gntcnt_q <= gntcnt_d;
        end
    end

    for (genvar g = 0; g < MASTERCOUNT; g++) begin : g_pack
        assign gntcnt_o[16*g +: 16] = gntcnt_q[g];
    end

    assign m_data_o = mdata_q;
    assign m_rdy_o  = rdy_q;
    assign m_err_o  = err_q;
    assign s_op_o   = s_op_q;
    assign s_addr_o = s_addr_q;
    assign s_data_o = s_data_q;
    assign s_sel_o  = s_sel_q;

endmodule
